// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: a combinational fetch read port, plus a loader write port
// that goes through a small write buffer whose entries are forwarded to reads.
module inst_sram_responder #(
  parameter logic [31:0] MEM_BASE   = 32'h1C00_0000,
  parameter int unsigned IDX_WIDTH  = 12,
  parameter int unsigned WBUF_DEPTH = 4,
  parameter logic [31:0] OOB_DATA   = 32'h0340_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_idle,
  output logic        oob_err,
  input  logic        err_clr
);

  localparam int unsigned PTR_W     = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned MEM_WORDS = 1 << IDX_WIDTH;
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(WBUF_DEPTH);

  logic [31:0] mem [MEM_WORDS];

  logic [IDX_WIDTH-1:0] wb_idx_q  [WBUF_DEPTH];
  logic [31:0]          wb_data_q [WBUF_DEPTH];
  logic                 wb_inr_q  [WBUF_DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             oob_err_q, oob_err_d;

  logic [31:0]          rd_off, ld_off;
  logic                 rd_in_range, ld_in_range;
  logic [IDX_WIDTH-1:0] rd_idx, ld_idx;

  logic        push;
  logic        drain_en;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        oob_set;

  // Unsigned subtraction: addresses below MEM_BASE wrap to huge offsets and fall out of range.
  assign rd_off      = inst_sram_addr - MEM_BASE;
  assign ld_off      = load_addr - MEM_BASE;
  assign rd_in_range = rd_off < MEM_BYTES;
  assign ld_in_range = ld_off < MEM_BYTES;
  assign rd_idx      = rd_off[IDX_WIDTH+1:2];
  assign ld_idx      = ld_off[IDX_WIDTH+1:2];

  assign load_ready = (count_q != DEPTH_CNT);
  assign load_idle  = (count_q == '0);
  assign oob_err    = oob_err_q;

  assign push     = load_valid && load_ready;
  assign drain_en = (count_q != '0);

  // Walk from oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && wb_inr_q[head_q + PTR_W'(i)] &&
          (wb_idx_q[head_q + PTR_W'(i)] == rd_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[head_q + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    inst_sram_rdata = mem[rd_idx];
    if (!rd_in_range) begin
      inst_sram_rdata = OOB_DATA;
    end else if (fwd_hit) begin
      inst_sram_rdata = fwd_data;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    if (drain_en) begin
      head_d = head_q + 1'b1;
    end
    unique case ({push, drain_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign oob_set = (rst_n && !rd_in_range) || (push && !ld_in_range);

  always_comb begin
    oob_err_d = oob_err_q;
    if (oob_set) begin
      oob_err_d = 1'b1;
    end else if (err_clr) begin
      oob_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      oob_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      oob_err_q <= oob_err_d;
    end
  end

  // Payload storage needs no reset: count_q alone defines which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_idx_q[tail_q]  <= ld_idx;
      wb_data_q[tail_q] <= load_data;
      wb_inr_q[tail_q]  <= ld_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (drain_en && wb_inr_q[head_q]) begin
      mem[wb_idx_q[head_q]] <= wb_data_q[head_q];
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder: a reference buffer/memory model predicts every
// read, handshake and error flag; expected read data flows through a scoreboard queue.
module tb_inst_sram_responder;

  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam int          DEPTH = 4;
  localparam logic [31:0] OOBD  = 32'h0340_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_idle;
  logic        oob_err;
  logic        err_clr;

  inst_sram_responder #(
    .MEM_BASE  (BASE),
    .IDX_WIDTH (12),
    .WBUF_DEPTH(DEPTH),
    .OOB_DATA  (OOBD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_idle      (load_idle),
    .oob_err        (oob_err),
    .err_clr        (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          inr;
  } ent_t;

  ent_t        m_buf[$];
  logic [31:0] m_mem[int];
  logic [31:0] exp_q[$];
  bit          m_err;
  bit          m_block;
  int          n_cmp;
  int          n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_oob(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off >= 32'h0000_4000;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[13:2]);
  endfunction

  function automatic void predict_read(input logic [31:0] a, output bit have,
                                       output logic [31:0] e);
    int idx;
    have = 1'b0;
    e    = '0;
    if (is_oob(a)) begin
      have = 1'b1;
      e    = OOBD;
      return;
    end
    idx = word_idx(a);
    for (int i = m_buf.size() - 1; i >= 0; i--) begin
      if (m_buf[i].inr && m_buf[i].idx == idx) begin
        have = 1'b1;
        e    = m_buf[i].data;
        return;
      end
    end
    if (m_mem.exists(idx)) begin
      have = 1'b1;
      e    = m_mem[idx];
    end
  endfunction

  // Entered and left at posedge+1; checks combinational outputs, then advances the model.
  task automatic cycle(input logic v, input logic [31:0] la, input logic [31:0] ld,
                       input logic [31:0] ra, input logic clr);
    bit          have;
    bit          acc;
    bit          pop;
    logic [31:0] e;
    ent_t        ent;
    load_valid     = v;
    load_addr      = la;
    load_data      = ld;
    inst_sram_addr = ra;
    err_clr        = clr;
    predict_read(ra, have, e);
    if (have) exp_q.push_back(e);
    #1;
    check_eq("load_ready", 32'(load_ready), 32'(m_buf.size() != DEPTH));
    check_eq("load_idle", 32'(load_idle), 32'(m_buf.size() == 0));
    check_eq("oob_err", 32'(oob_err), 32'(m_err));
    if (have) check_eq("rdata", inst_sram_rdata, exp_q.pop_front());
    @(posedge clk);
    acc = v && (m_buf.size() != DEPTH);
    pop = (m_buf.size() != 0) && !m_block;
    if (pop) begin
      ent = m_buf.pop_front();
      if (ent.inr) m_mem[ent.idx] = ent.data;
    end
    if (acc) begin
      ent.idx  = word_idx(la);
      ent.data = ld;
      ent.inr  = !is_oob(la);
      m_buf.push_back(ent);
    end
    if (is_oob(ra) || (acc && is_oob(la))) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    #1;
  endtask

  task automatic idle_read(input logic [31:0] ra, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, ra, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_err = 1'b0;
    m_block = 1'b0;
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_addr = '0;
    load_data = '0;
    inst_sram_addr = BASE;
    err_clr = 1'b0;
    #3;
    check_eq("rst_idle", 32'(load_idle), 32'd1);
    check_eq("rst_ready", 32'(load_ready), 32'd1);
    check_eq("rst_oob", 32'(oob_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back loads with fetch watching word 2.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, BASE + 32'(4 * i), 32'h11 * 32'(i + 1), BASE + 32'h8, 1'b0);
    idle_read(BASE + 32'h8, 3);

    // Write-after-write to the same word.
    cycle(1'b1, BASE + 32'h10, 32'hAAAA, BASE + 32'h10, 1'b0);
    cycle(1'b1, BASE + 32'h10, 32'hBBBB, BASE + 32'h10, 1'b0);
    idle_read(BASE + 32'h10, 3);

    // Sustained pushes; drain keeps pace.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, BASE + 32'h20 + 32'(4 * i), 32'h100 + 32'(i), BASE + 32'h20, 1'b0);
    for (int i = 0; i < 6; i++) idle_read(BASE + 32'h20 + 32'(4 * i), 1);

    // Drain blocked: buffer fills, then rejects, then drains intact.
    force dut.drain_en = 1'b0;
    m_block = 1'b1;
    for (int i = 0; i < 6; i++)
      cycle(1'b1, BASE + 32'h40 + 32'(4 * i), 32'h200 + 32'(i), BASE + 32'h44, 1'b0);
    for (int i = 0; i < 4; i++) idle_read(BASE + 32'h40 + 32'(4 * i), 1);
    release dut.drain_en;
    m_block = 1'b0;
    idle_read(BASE + 32'h4C, 5);
    for (int i = 0; i < 6; i++) idle_read(BASE + 32'h40 + 32'(4 * i), 1);

    // Read-side out-of-range and error clear.
    idle_read(32'h1BFF_FFFC, 1);
    idle_read(32'h1C00_4000, 1);
    cycle(1'b0, '0, '0, BASE + 32'h8, 1'b1);
    idle_read(BASE + 32'h8, 1);
    idle_read(32'h1C00_4000, 1);
    cycle(1'b0, '0, '0, 32'h1C00_4000, 1'b1);
    idle_read(BASE, 1);
    cycle(1'b0, '0, '0, BASE, 1'b1);
    idle_read(BASE, 1);

    // Out-of-range push: accepted, flagged, never written.
    cycle(1'b1, 32'h2000_0000, 32'hDEAD, BASE + 32'h4, 1'b0);
    idle_read(BASE + 32'h4, 2);
    for (int i = 0; i < 4; i++) idle_read(BASE + 32'(4 * i), 1);

    // Reset with three undrained entries.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, BASE + 32'h100 + 32'(4 * i), 32'h500 + 32'(i), BASE, 1'b0);
    idle_read(BASE, 2);
    force dut.drain_en = 1'b0;
    m_block = 1'b1;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, BASE + 32'h100 + 32'(4 * i), 32'h600 + 32'(i), BASE + 32'h100, 1'b0);
    load_valid = 1'b0;
    inst_sram_addr = BASE;
    #2;
    rst_n = 1'b0;
    m_buf.delete();
    m_err = 1'b0;
    #1;
    check_eq("midrst_idle", 32'(load_idle), 32'd1);
    check_eq("midrst_ready", 32'(load_ready), 32'd1);
    check_eq("midrst_oob", 32'(oob_err), 32'd0);
    release dut.drain_en;
    m_block = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_read(BASE + 32'h100 + 32'(4 * i), 1);

    if (exp_q.size() != 0) check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
